histogram_ctrl: RTL and testbench
=================================

# histogram_ctrl

Frame-level sequencer and bin store for the histogram datapath. It clears its bin array on command, then accepts a pixel stream and increments one bin per accepted beat. On the frame's last beat it streams all bin counts out under valid/ready backpressure, then returns to idle. It sits between the pixel source and the downstream consumer of per-frame histogram results.

## Interface
- C_DATA_WIDTH, 8, input pixel width
- C_QUANTITY, 16, number of bins (power of two, ≥2)
- C_COUNT_WIDTH, 16, width of each bin counter

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- start_i  in  1  begin new frame (sampled only in IDLE)
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i & ready_o
- last_i  in  1  marks final beat of frame (qualified by valid_i & ready_o)
- data_i  in  C_DATA_WIDTH  pixel value
- valid_o  out  1  output bin valid
- ready_i  in  1  downstream ready
- last_o  out  1  high with bin C_QUANTITY-1
- bin_o  out  $clog2(C_QUANTITY)  bin index of current output
- count_o  out  C_COUNT_WIDTH  count for bin_o
- busy_o  out  1  state != IDLE
- overflow_o  out  1  sticky: some bin saturated during current/last frame

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DUMP.
- IDLE: ready_o=0, valid_o=0. start_i=1 -> CLEAR; overflow_o cleared on this transition.
- CLEAR: zero one bin per cycle, index 0..C_QUANTITY-1; after index C_QUANTITY-1 -> ACCUM. ready_o=0.
- ACCUM: ready_o=1. Each accepted beat: bin = data_i if data_i < C_QUANTITY, else C_QUANTITY-1 (clamp, no wrap). count[bin] += 1, saturating at 2^C_COUNT_WIDTH-1; an increment attempted at max sets overflow_o. Accepted beat with last_i=1 is counted, then -> DUMP. valid_i=0 beats ignored, including any last_i on them.
- DUMP: valid_o=1, bin_o = dump index starting at 0, count_o = count[bin_o], last_o = (bin_o == C_QUANTITY-1). Index advances only on valid_o & ready_i. Handshake with last_o=1 -> IDLE.
- start_i outside IDLE is ignored. No input accepted outside ACCUM.
- Bin array is a register array: increment is single-cycle read-modify-write, so back-to-back hits on the same bin need no forwarding.
- Outputs are driven only from state, index and array registers. There is no combinational path from any input to any output.
- Reset (rstn_i=0 at an edge), in any state including mid-CLEAR, ACCUM or DUMP: state=IDLE, indices=0, overflow_o=0. Array contents need not be reset, because CLEAR always precedes use.

## Timing
- Reset values: ready_o=0, valid_o=0, last_o=0, bin_o=0, count_o=0 (bin 0 with array zeroed, or masked to 0 outside DUMP), busy_o=0, overflow_o=0.
- count_o and bin_o are forced to 0 outside DUMP.
- start_i high at edge t -> busy_o=1 after t. CLEAR occupies cycles t+1..t+C_QUANTITY. ready_o=1 from cycle t+C_QUANTITY+1.
- Beat accepted at edge a updates its bin visible from a+1.
- Last beat accepted at edge a -> ready_o=0 and valid_o=1 (bin 0) in cycle a+1.
- With ready_i held at 1, DUMP lasts exactly C_QUANTITY cycles. With ready_i=0, bin_o and count_o hold stable.
- Final handshake at edge d -> IDLE in cycle d+1. A new start_i is accepted at edge d+1 or later.

## Test plan
- Reset: hold rstn_i=0 for 3 cycles with random inputs -> all outputs 0, ready_o=0. Then assert start_i -> ready_o=1 exactly 17 cycles later (defaults).
- Basic frame: pixels 0..15 once each, last_i on pixel 15, ready_i=1 -> 16 output beats, bin_o 0..15, count_o=1 each, last_o only on bin 15, overflow_o=0.
- Clamp and gaps: beats 3,3,200,15,255 with random valid_i gaps, last on 255 -> bin3=2, bin15=3, all others 0.
- Saturation (C_COUNT_WIDTH=4): 20 beats of value 5 -> bin5=15, overflow_o=1. Next start_i clears overflow_o to 0.
- Backpressure and ignored start: ready_i toggled randomly in DUMP -> bin_o/count_o stable while ready_i=0, order 0..15 preserved. start_i pulsed during ACCUM and DUMP -> no effect.
- Reset mid-ACCUM then new frame with pixels {7}, last -> bin7=1, all other bins 0 (no stale counts). A second back-to-back frame is also cleared.

Source files
------------

// File: rtl/histogram_ctrl.sv
// Frame histogram sequencer: clears bins, counts a pixel stream, then dumps bins.
// Ports: clk_i/rstn_i, start_i, pixel in (valid_i/ready_o/last_i/data_i), bins out (valid_o/ready_i/last_o/bin_o/count_o), busy_o, overflow_o.
module histogram_ctrl #(
  parameter int C_DATA_WIDTH  = 8,
  parameter int C_QUANTITY    = 16,
  parameter int C_COUNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          last_i,
  input  logic [C_DATA_WIDTH-1:0]       data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          last_o,
  output logic [$clog2(C_QUANTITY)-1:0] bin_o,
  output logic [C_COUNT_WIDTH-1:0]      count_o,
  output logic                          busy_o,
  output logic                          overflow_o
);

  localparam int IW = $clog2(C_QUANTITY);

  typedef enum logic [1:0] {
    IDLE, CLEAR, ACCUM, DUMP
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [IW-1:0]            idx_q;
  logic [C_COUNT_WIDTH-1:0] bins_q [C_QUANTITY];
  logic                     ovf_q;

  logic          accept;
  logic          idx_last;
  logic          hit_max;
  logic          in_dump;
  logic [IW-1:0] sel;

  assign accept   = (state_q == ACCUM) & valid_i;
  assign idx_last = idx_q == IW'(C_QUANTITY - 1);
  assign in_dump  = state_q == DUMP;

  // Out-of-range pixels land in the top bin rather than wrapping.
  assign sel = (32'(data_i) < C_QUANTITY) ?
               data_i[IW-1:0] : IW'(C_QUANTITY - 1);

  assign hit_max = bins_q[sel] == '1;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)           state_d = CLEAR;
      CLEAR:   if (idx_last)          state_d = ACCUM;
      ACCUM:   if (accept && last_i)  state_d = DUMP;
      DUMP:    if (ready_i && idx_last) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // One index serves both CLEAR and DUMP; it wraps to 0
  // at the end of each pass since C_QUANTITY is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      idx_q <= '0;
    end else begin
      unique case (state_q)
        CLEAR:   idx_q <= idx_q + 1'b1;
        DUMP:    if (ready_i) idx_q <= idx_q + 1'b1;
        default: idx_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      ovf_q <= 1'b0;
    end else if (accept && hit_max) begin
      ovf_q <= 1'b1;
    end
  end

  // No reset: CLEAR always runs before the array is read.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      bins_q[idx_q] <= '0;
    end else if (accept && !hit_max) begin
      bins_q[sel] <= bins_q[sel] + 1'b1;
    end
  end

  always_comb begin
    ready_o    = state_q == ACCUM;
    valid_o    = in_dump;
    busy_o     = state_q != IDLE;
    last_o     = in_dump & idx_last;
    bin_o      = in_dump ? idx_q : '0;
    count_o    = in_dump ? bins_q[idx_q] : '0;
    overflow_o = ovf_q;
  end

endmodule

// File: tb/tb_histogram_ctrl.sv
// Directed self-checking bench for histogram_ctrl.
// Narrow counters (4 bits) so saturation is reachable in a short frame.
module tb_histogram_ctrl;

  localparam int DW = 8;
  localparam int Q  = 16;
  localparam int CW = 4;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          start_i;
  logic          valid_i;
  logic          ready_o;
  logic          last_i;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic [IW-1:0] bin_o;
  logic [CW-1:0] count_o;
  logic          busy_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;
  int expc [Q];

  always #5 clk_i = ~clk_i;

  histogram_ctrl #(
    .C_DATA_WIDTH (DW),
    .C_QUANTITY   (Q),
    .C_COUNT_WIDTH(CW)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (start_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .last_i    (last_i),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .last_o    (last_o),
    .bin_o     (bin_o),
    .count_o   (count_o),
    .busy_o    (busy_o),
    .overflow_o(overflow_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < Q; i++) expc[i] = 0;
  endtask

  task automatic start_frame();
    int n;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL start_busy busy_o=%0b exp 1", busy_o);
    end
    n = 0;
    while (!ready_o && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clear_len ready after %0d cycles exp 16", n);
    end
  endtask

  task automatic send(input int d, input bit l);
    valid_i = 1'b1;
    data_i  = DW'(d);
    last_i  = l;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_ready ready_o=%0b exp 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b0;
      last_i  = 1'($urandom_range(0, 1));
      data_i  = DW'($urandom_range(0, 255));
      tick();
    end
    last_i = 1'b0;
  endtask

  task automatic run_dump(input bit bp, input bit poke);
    int k;
    int n;
    bit hs;
    k = 0;
    n = 0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL dump_ready ready_o=%0b exp 0", ready_o);
    end
    while (k < Q && n < 200) begin
      ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      checks++;
      if (valid_o !== 1'b1 || bin_o !== IW'(k) ||
          count_o !== CW'(expc[k]) || last_o !== (k == Q - 1)) begin
        errors++;
        $display("FAIL dump_beat k=%0d valid=%0b bin=%0d count=%0d last=%0b exp count=%0d",
                 k, valid_o, bin_o, count_o, last_o, expc[k]);
      end
      hs = ready_i;
      tick();
      n++;
      if (hs) k++;
    end
    ready_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (k != Q || valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL dump_end beats=%0d valid=%0b busy=%0b exp %0d 0 0",
               k, valid_o, busy_o, Q);
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_i = 1'($urandom_range(0, 1));
      valid_i = 1'($urandom_range(0, 1));
      last_i  = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
      data_i  = DW'($urandom_range(0, 255));
      tick();
    end
    checks++;
    if ({ready_o, valid_o, last_o, busy_o, overflow_o} !== 5'b0 ||
        bin_o !== '0 || count_o !== '0) begin
      errors++;
      $display("FAIL reset_outs r=%0b v=%0b l=%0b b=%0b o=%0b bin=%0d cnt=%0d exp all 0",
               ready_o, valid_o, last_o, busy_o, overflow_o, bin_o, count_o);
    end
    start_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b0;
    rstn_i  = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_outs busy=%0b ready=%0b exp 0 0", busy_o, ready_o);
    end
  endtask

  task automatic test_basic();
    clear_exp();
    for (int i = 0; i < Q; i++) begin
      send(i, i == Q - 1);
      expc[i] = 1;
    end
    run_dump(1'b0, 1'b0);
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf overflow_o=%0b exp 0", overflow_o);
    end
  endtask

  task automatic test_clamp();
    start_frame();
    clear_exp();
    send(3, 1'b0);
    gap(2);
    send(3, 1'b0);
    gap(1);
    send(200, 1'b0);
    send(15, 1'b0);
    gap(3);
    send(255, 1'b1);
    expc[3]  = 2;
    expc[15] = 3;
    run_dump(1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    start_frame();
    clear_exp();
    for (int i = 0; i < 20; i++) send(5, i == 19);
    expc[5] = 15;
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf overflow_o=%0b exp 1", overflow_o);
    end
    run_dump(1'b0, 1'b0);
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky overflow_o=%0b exp 1", overflow_o);
    end
    start_frame();
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear overflow_o=%0b exp 0", overflow_o);
    end
    clear_exp();
    send(0, 1'b1);
    expc[0] = 1;
    run_dump(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    start_frame();
    clear_exp();
    start_i = 1'b1;
    send(1, 1'b0);
    send(2, 1'b0);
    start_i = 1'b0;
    send(2, 1'b0);
    start_i = 1'b1;
    send(10, 1'b0);
    send(2, 1'b1);
    start_i = 1'b0;
    expc[1]  = 1;
    expc[2]  = 3;
    expc[10] = 1;
    run_dump(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear busy=%0b ready=%0b exp 0 0", busy_o, ready_o);
    end
    start_frame();
    for (int i = 0; i < 3; i++) send(4, 1'b0);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_accum busy=%0b ready=%0b ovf=%0b exp 0 0 0",
               busy_o, ready_o, overflow_o);
    end
    start_frame();
    clear_exp();
    send(7, 1'b1);
    expc[7] = 1;
    run_dump(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_frame();
    clear_exp();
    send(9, 1'b1);
    expc[9] = 1;
    run_dump(1'b0, 1'b0);
  endtask

  initial begin
    rstn_i  = 1'b0;
    start_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    test_reset();
    start_frame();
    test_basic();
    test_clamp();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
